buzzer_tone_driver: RTL and testbench

- Downstream stage of the sensor/buzzer controller.
- Consumes the controller's three level-type buzzer enables and turns the highest-priority one into an audible square-wave tone on a single speaker pin.
- Each channel has its own pitch, and the tone is gated by a repeating beep cadence (on/off).
- Also drives a one-hot indication of which channel is currently sounding.

---
 rtl/buzzer_tone_driver_pkg.sv | 34 +++
 rtl/buzzer_tone_driver_tone_tick_prescaler.sv | 32 +++
 rtl/buzzer_tone_driver.sv | 155 +++++++++++++++
 tb/tb_buzzer_tone_driver.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/buzzer_tone_driver_pkg.sv
// Shared types and helpers for the buzzer tone driver: FSM encoding, channel count and
// the priority encoder that picks the sounding channel.
package buzzer_tone_driver_pkg;

    localparam int unsigned NCH = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StOff  = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0]     idx;
        logic [NCH-1:0] onehot;
        logic           any;
    } sel_t;

    // Lowest set bit wins: bit0 beats bit1, bit1 beats bit2.
    function automatic sel_t prio_encode(input logic [NCH-1:0] en);
        sel_t s;
        s     = '0;
        s.any = |en;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (en[i]) begin
                s.idx       = 2'(i);
                s.onehot    = '0;
                s.onehot[i] = 1'b1;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/buzzer_tone_driver_tone_tick_prescaler.sv
// Tone tick prescaler: free-running 0..PRESCALE-1 counter with a synchronous clear;
// tick is high on the last count.
module buzzer_tone_driver_tone_tick_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ena) begin
            if (clr || cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/buzzer_tone_driver.sv
// Buzzer tone driver: selects the highest-priority buzzer enable and plays its square-wave
// pitch on the speaker pin, gated by an on/off beep cadence.
module buzzer_tone_driver
    import buzzer_tone_driver_pkg::*;
#(
    parameter int unsigned PRESCALE  = 4,
    parameter int unsigned HALF0     = 2,
    parameter int unsigned HALF1     = 3,
    parameter int unsigned HALF2     = 4,
    parameter int unsigned ON_TICKS  = 8,
    parameter int unsigned OFF_TICKS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic [NCH-1:0] buzz_en,
    output logic           tone_out,
    output logic [NCH-1:0] chan_active,
    output logic           busy
);

    localparam int unsigned HALF_MAX01 = (HALF0 > HALF1) ? HALF0 : HALF1;
    localparam int unsigned HALF_MAX   = (HALF_MAX01 > HALF2) ? HALF_MAX01 : HALF2;
    localparam int unsigned CAD_MAX    = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned TW         = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
    localparam int unsigned CADW       = (CAD_MAX > 1) ? $clog2(CAD_MAX) : 1;

    if (PRESCALE == 0 || HALF0 == 0 || HALF1 == 0 || HALF2 == 0 ||
        ON_TICKS == 0 || OFF_TICKS == 0) begin : gen_bad_param
        $fatal(1, "buzzer_tone_driver: all parameters must be >= 1");
    end

    function automatic logic [TW-1:0] half_last(input logic [1:0] idx);
        unique case (idx)
            2'd0:    return TW'(HALF0 - 1);
            2'd1:    return TW'(HALF1 - 1);
            default: return TW'(HALF2 - 1);
        endcase
    endfunction

    state_e          state;
    logic [TW-1:0]   tone_cnt;
    logic [CADW-1:0] cad_cnt;
    logic            phase;
    logic [1:0]      ch_idx;

    sel_t sel;
    logic tick;
    logic go_idle;
    logic go_on_new;
    logic cad_end_on;
    logic cad_end_off;
    logic tone_wrap;
    logic presc_clr;

    always_comb begin
        sel         = prio_encode(buzz_en);
        go_idle     = (state != StIdle) && !sel.any;
        // A change of selected channel restarts ON, ahead of any cadence transition.
        go_on_new   = sel.any && (state == StIdle || sel.onehot != chan_active);
        cad_end_on  = (state == StOn) && tick && (cad_cnt == CADW'(ON_TICKS - 1));
        cad_end_off = (state == StOff) && tick && (cad_cnt == CADW'(OFF_TICKS - 1));
        tone_wrap   = tick && (tone_cnt == half_last(ch_idx));
        presc_clr   = !go_idle && (go_on_new || cad_end_on || cad_end_off);
    end

    buzzer_tone_driver_tone_tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .clr  (presc_clr),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= StIdle;
            tone_cnt    <= '0;
            cad_cnt     <= '0;
            phase       <= 1'b1;
            ch_idx      <= '0;
            tone_out    <= 1'b0;
            chan_active <= '0;
            busy        <= 1'b0;
        end else if (ena) begin
            if (go_idle) begin
                state       <= StIdle;
                tone_cnt    <= '0;
                cad_cnt     <= '0;
                phase       <= 1'b1;
                tone_out    <= 1'b0;
                chan_active <= '0;
                busy        <= 1'b0;
            end else if (go_on_new) begin
                state       <= StOn;
                tone_cnt    <= '0;
                cad_cnt     <= '0;
                phase       <= 1'b1;
                ch_idx      <= sel.idx;
                tone_out    <= 1'b1;
                chan_active <= sel.onehot;
                busy        <= 1'b1;
            end else begin
                unique case (state)
                    StOn: begin
                        if (cad_end_on) begin
                            state    <= StOff;
                            cad_cnt  <= '0;
                            tone_cnt <= '0;
                            phase    <= 1'b1;
                            tone_out <= 1'b0;
                        end else if (tick) begin
                            cad_cnt <= cad_cnt + CADW'(1);
                            if (tone_wrap) begin
                                tone_cnt <= '0;
                                phase    <= !phase;
                                tone_out <= !phase;
                            end else begin
                                tone_cnt <= tone_cnt + TW'(1);
                            end
                        end
                    end
                    StOff: begin
                        tone_cnt <= '0;
                        phase    <= 1'b1;
                        if (cad_end_off) begin
                            state    <= StOn;
                            cad_cnt  <= '0;
                            tone_out <= 1'b1;
                        end else begin
                            tone_out <= 1'b0;
                            if (tick) begin
                                cad_cnt <= cad_cnt + CADW'(1);
                            end
                        end
                    end
                    StIdle: begin
                        tone_cnt <= '0;
                        cad_cnt  <= '0;
                        phase    <= 1'b1;
                    end
                    default: begin
                        state       <= StIdle;
                        tone_out    <= 1'b0;
                        chan_active <= '0;
                        busy        <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_buzzer_tone_driver.sv
// Randomized bench for buzzer_tone_driver against an elapsed-time reference model.
module tb_buzzer_tone_driver;

    localparam int P         = 4;
    localparam int ON_TICKS  = 8;
    localparam int OFF_TICKS = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [2:0] buzz_en;
    logic       tone_out;
    logic [2:0] chan_active;
    logic       busy;

    int half[3] = '{2, 3, 4};

    int n_vec = 0;
    int n_err = 0;

    // Model: mode 0 idle, 1 on, 2 off; m_e = clocks elapsed in the current ON/OFF segment.
    int m_mode = 0;
    int m_ch   = 0;
    int m_e    = 0;

    always #5 clk = ~clk;

    buzzer_tone_driver u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .buzz_en    (buzz_en),
        .tone_out   (tone_out),
        .chan_active(chan_active),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_edge();
        int sel;
        sel = -1;
        for (int i = 2; i >= 0; i--) if (buzz_en[i]) sel = i;
        if (!rst_n) begin
            m_mode = 0;
            m_e    = 0;
        end else if (ena) begin
            if (m_mode == 0) begin
                if (sel >= 0) begin
                    m_mode = 1;
                    m_ch   = sel;
                    m_e    = 0;
                end
            end else if (sel < 0) begin
                m_mode = 0;
                m_e    = 0;
            end else if (sel != m_ch) begin
                m_mode = 1;
                m_ch   = sel;
                m_e    = 0;
            end else begin
                m_e++;
                if (m_mode == 1 && m_e == ON_TICKS * P) begin
                    m_mode = 2;
                    m_e    = 0;
                end else if (m_mode == 2 && m_e == OFF_TICKS * P) begin
                    m_mode = 1;
                    m_e    = 0;
                end
            end
        end
    endfunction

    task automatic step(input string tag);
        logic       exp_tone;
        logic [2:0] exp_chan;
        @(posedge clk);
        model_edge();
        #1;
        exp_tone = (m_mode == 1) && (((m_e / (half[m_ch] * P)) % 2) == 0);
        exp_chan = (m_mode == 0) ? 3'b000 : 3'(1 << m_ch);
        check({tag, ".tone"}, 32'(tone_out), 32'(exp_tone));
        check({tag, ".chan"}, 32'(chan_active), 32'(exp_chan));
        check({tag, ".busy"}, 32'(busy), 32'(m_mode != 0));
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        rst_n   = 1'b0;
        ena     = 1'b1;
        buzz_en = 3'b000;
        run("reset", 3);
        rst_n = 1'b1;
        run("idle", 2);

        buzz_en = 3'b001;
        run("ch0", 100);

        buzz_en = 3'b100;
        run("ch2", 100);

        buzz_en = 3'b100;
        run("ch2_pre", 10);
        buzz_en = 3'b110;
        run("preempt", 60);

        buzz_en = 3'b000;
        run("drop", 3);
        buzz_en = 3'b001;
        run("on5", 5);
        buzz_en = 3'b000;
        run("drop5", 2);
        buzz_en = 3'b001;
        run("fresh", 40);

        run("pre_hold", 3);
        ena = 1'b0;
        run("hold", 10);
        ena = 1'b1;
        run("resume", 40);

        ena   = 1'b0;
        rst_n = 1'b0;
        run("rst_hold", 1);
        rst_n = 1'b1;
        ena   = 1'b1;
        run("reenter", 40);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom % 40 == 0) buzz_en = 3'($urandom);
            ena   = ($urandom % 16) != 0;
            rst_n = ($urandom % 500) != 0;
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
